pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 26 ++
 rtl/pipe_ctrl_md_busy_cnt.sv | 45 ++++
 rtl/pipe_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// pipe_ctrl_pkg : shared state encoding and default timing/handler constants
// Rev 1.0
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int          c_mult_cycles = 5;
    localparam int          c_div_cycles  = 10;
    localparam logic [31:0] c_handler_pc  = 32'h0000_4180;

    // Counter width able to hold the longer of the two operation latencies.
    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_md_busy_cnt.sv
// ============================================================================
// md_busy_cnt : multiply/divide busy down-counter (load, decrement, busy)
// Rev 1.0
// ============================================================================
`default_nettype none

module md_busy_cnt
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = c_mult_cycles,
    parameter int DIV_CYCLES  = c_div_cycles
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy,
    output logic last
);

    localparam int              c_w       = cnt_width(MULT_CYCLES, DIV_CYCLES);
    localparam logic [c_w-1:0]  c_mult_ld = c_w'(MULT_CYCLES);
    localparam logic [c_w-1:0]  c_div_ld  = c_w'(DIV_CYCLES);
    localparam logic [c_w-1:0]  c_one     = c_w'(1);

    logic [c_w-1:0] r_count;

    // A start while the unit is still busy is dropped; the count keeps running.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (start && (r_count == '0)) begin
            r_count <= is_div ? c_div_ld : c_mult_ld;
        end else if (r_count != '0) begin
            r_count <= r_count - c_one;
        end
    end

    assign busy = (r_count != '0);
    // High when busy will be low in the next cycle.
    assign last = (r_count <= c_one);

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// pipe_ctrl : hazard stalls and precise interrupt entry; the mult/div interlock
//             and DRAIN state are built only when PIPE_CTRL_MD_EN is defined
// Rev 1.0
// ============================================================================
`default_nettype none

module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int          MULT_CYCLES = c_mult_cycles,
    parameter int          DIV_CYCLES  = c_div_cycles,
    parameter logic [31:0] HANDLER_PC  = c_handler_pc
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic        d_use_rs,
    input  logic        d_use_rt,
    input  logic        d_md_use,
    input  logic        e_load,
    input  logic [4:0]  e_wreg,
    input  logic        md_start,
    input  logic        md_is_div,
    input  logic        irq,
    input  logic        eret_M,
    input  logic [31:0] pc_M,
    output logic        stall_F,
    output logic        stall_D,
    output logic        flush_E,
    output logic        int_clr,
    output logic        pc_sel_handler,
    output logic [31:0] epc,
    output logic        exl,
    output logic        md_busy
);

    // The handler address is applied by the PC mux outside this block.
    localparam logic [31:0] c_unused_handler = HANDLER_PC;

    state_t      r_state;
    logic [31:0] r_epc;
    logic        r_exl;
    logic        w_md_busy;
    logic        w_md_last;
    logic        w_md_hazard;
    logic        w_load_hazard;
    logic        w_stall;

`ifdef PIPE_CTRL_MD_EN
    md_busy_cnt #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_cnt (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start),
        .is_div (md_is_div),
        .busy   (w_md_busy),
        .last   (w_md_last)
    );

    assign w_md_hazard = d_md_use && (w_md_busy || md_start);
`else
    localparam int c_unused_cycles = MULT_CYCLES + DIV_CYCLES;
    logic          w_unused_md;

    assign w_unused_md = ^{d_md_use, md_start, md_is_div};
    assign w_md_busy   = 1'b0;
    assign w_md_last   = 1'b1;
    assign w_md_hazard = 1'b0;
`endif

    assign w_load_hazard = e_load && (e_wreg != 5'd0) &&
                           ((d_use_rs && (e_wreg == d_rs)) ||
                            (d_use_rt && (e_wreg == d_rt)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
            r_epc   <= 32'd0;
            r_exl   <= 1'b0;
        end else begin
            if (eret_M) begin
                r_exl <= 1'b0;
            end
            case (r_state)
                RUN: begin
                    if (irq && !r_exl) begin
                        r_state <= w_md_busy ? DRAIN : FLUSH;
                    end
                end
                DRAIN: begin
                    // Leave for FLUSH so it lands in the first idle mult/div cycle.
                    if (!irq) begin
                        r_state <= RUN;
                    end else if (w_md_last) begin
                        r_state <= FLUSH;
                    end
                end
                FLUSH: begin
                    r_epc   <= pc_M;
                    r_exl   <= 1'b1;
                    r_state <= RUN;
                end
                default: r_state <= RUN;
            endcase
        end
    end

    assign w_stall = (r_state == DRAIN) ||
                     ((r_state == RUN) && (w_load_hazard || w_md_hazard));

    assign stall_F        = w_stall;
    assign stall_D        = w_stall;
    assign flush_E        = w_stall;
    assign int_clr        = (r_state == FLUSH);
    assign pc_sel_handler = (r_state == FLUSH);
    assign epc            = r_epc;
    assign exl            = r_exl;
    assign md_busy        = w_md_busy;

endmodule

`default_nettype wire
